// File: rtl/pipe_skid_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf_if
// Description : Handshake bundle for pipe_skid_buf. It carries the upstream
//               (s_*) and downstream (m_*) valid/ready/data channels.
//               The slave modport is the buffer's view of the bundle.
//               The master modport is the view of the surrounding
//               producer/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_buf_if #(
    parameter int WIDTH = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport slave (
        input  s_valid,
        output s_ready,
        input  s_data,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport master (
        output s_valid,
        input  s_ready,
        output s_data,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Two-entry skid buffer. It has a registered s_ready and a
//               registered m_data, with one cycle of latency and full
//               throughput. The main register drives m_data. The skid
//               register catches the one beat accepted while downstream
//               stalls. flush empties the buffer synchronously and leaves
//               the payload registers untouched.
//               Optional feature: define PIPE_SKID_BUF_STALL_CNT_EN to add
//               a saturating 16-bit stall_cnt output. It counts the cycles
//               in which m_valid is high and m_ready is low.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           flush,
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    output      logic [15:0]    stall_cnt,
`endif
    pipe_skid_buf_if.slave      bus
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_BUSY  = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_s_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;
    logic             w_m_valid;

    // State register and registered s_ready. s_ready looks one state ahead,
    // so it drops in the same cycle that the skid register fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_EMPTY;
            r_s_ready <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_s_ready <= (w_next_state != c_ST_FULL);
        end
    end

    // Next-state and load-enable decode. flush takes priority and blocks
    // every payload load.
    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                if (bus.s_valid) begin
                    w_load_main  = 1'b1;
                    w_next_state = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (bus.s_valid && bus.m_ready) begin
                    w_load_main = 1'b1;
                end else if (bus.s_valid && !bus.m_ready) begin
                    w_load_skid  = 1'b1;
                    w_next_state = c_ST_FULL;
                end else if (!bus.s_valid && bus.m_ready) begin
                    w_next_state = c_ST_EMPTY;
                end
            end
            c_ST_FULL: begin
                // s_ready is low here, so upstream data is not looked at.
                if (bus.m_ready) begin
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_next_state     = c_ST_BUSY;
                end
            end
            default: begin
                w_next_state = c_ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_next_state     = c_ST_EMPTY;
            w_load_main      = 1'b0;
            w_load_skid      = 1'b0;
            w_main_from_skid = 1'b0;
        end
    end

    // Output decode: data is waiting downstream whenever the buffer is
    // not empty.
    always_comb begin
        w_m_valid = (r_state != c_ST_EMPTY);
    end

    // Payload registers. They load only on the enables decoded above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= RESET_VALUE;
            r_skid <= RESET_VALUE;
        end else begin
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : bus.s_data;
            end
            if (w_load_skid) begin
                r_skid <= bus.s_data;
            end
        end
    end

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of back-pressured cycles; flush clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (flush) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_m_valid && !bus.m_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = r_main;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_buf
// Description : Self-checking bench for pipe_skid_buf. A negedge monitor
//               keeps an expected-beat queue: it pushes on upstream
//               transfers and pops and compares on downstream transfers.
//               Directed checks cover reset, latency, back-pressure,
//               flush and asynchronous reset. The stall counter is
//               checked when PIPE_SKID_BUF_STALL_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_buf;

    localparam int c_WIDTH = 8;

    logic clk;
    logic rst_n;
    logic flush;
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipe_skid_buf_if #(.WIDTH(c_WIDTH)) bus ();

    pipe_skid_buf #(
        .WIDTH       (c_WIDTH),
        .RESET_VALUE ({c_WIDTH{1'b0}})
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [c_WIDTH-1:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor. Inputs are stable at the falling edge, so this
    // sees exactly the handshakes that the next rising edge will commit.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check_val("m_data_order", 32'(bus.m_data), 32'(sb.pop_front()));
                    n_out++;
                end
            end
            if (flush) begin
                sb.delete();
            end else if (bus.s_valid && bus.s_ready) begin
                sb.push_back(bus.s_data);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_val("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check_val("rst_m_data",  32'(bus.m_data),  32'd0);
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
        check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // First beat at the first edge after reset release, one-cycle latency
        rst_n       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        bus.m_ready = 1'b1;
        tick();
        check_val("first_m_valid", 32'(bus.m_valid), 32'd1);
        check_val("first_m_data",  32'(bus.m_data),  32'hA5);

        // Full-throughput stream 01..10
        for (int i = 1; i <= 16; i++) begin
            bus.s_data = 8'(i);
            tick();
            check_val("stream_s_ready", 32'(bus.s_ready), 32'd1);
            check_val("stream_m_valid", 32'(bus.m_valid), 32'd1);
            check_val("stream_m_data",  32'(bus.m_data),  32'(i));
        end
        bus.s_valid = 1'b0;
        tick();
        check_val("drain_m_valid", 32'(bus.m_valid), 32'd0);

        // Back-pressure: skid fills, s_ready drops, nothing is lost
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        tick();
        check_val("bp_s_ready_busy", 32'(bus.s_ready), 32'd1);
        bus.s_data = 8'h22;
        tick();
        check_val("bp_s_ready_full", 32'(bus.s_ready), 32'd0);
        check_val("bp_m_data_full",  32'(bus.m_data),  32'h11);
        bus.s_data = 8'h33;
        tick();
        tick();
        check_val("bp_hold_m_data",  32'(bus.m_data),  32'h11);
        check_val("bp_hold_m_valid", 32'(bus.m_valid), 32'd1);
        check_val("bp_hold_s_ready", 32'(bus.s_ready), 32'd0);
        bus.m_ready = 1'b1;
        tick();
        check_val("bp_rel_m_data",  32'(bus.m_data),  32'h22);
        check_val("bp_rel_s_ready", 32'(bus.s_ready), 32'd1);
        tick();
        check_val("bp_last_m_data", 32'(bus.m_data), 32'h33);
        bus.s_valid = 1'b0;
        tick();
        check_val("bp_drain_m_valid", 32'(bus.m_valid), 32'd0);

        // Flush from FULL: both beats discarded, payload untouched
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        tick();
        bus.s_data = 8'h22;
        tick();
        bus.s_valid = 1'b0;
        flush       = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush_m_valid", 32'(bus.m_valid), 32'd0);
        check_val("flush_s_ready", 32'(bus.s_ready), 32'd1);
        check_val("flush_m_data",  32'(bus.m_data),  32'h11);

        // A beat offered during flush is dropped
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        flush       = 1'b1;
        tick();
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        check_val("flush_drop_m_valid", 32'(bus.m_valid), 32'd0);
        check_val("flush_drop_m_data",  32'(bus.m_data),  32'h11);
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h66;
        tick();
        bus.s_valid = 1'b0;
        check_val("post_flush_m_valid", 32'(bus.m_valid), 32'd1);
        check_val("post_flush_m_data",  32'(bus.m_data),  32'h66);
        tick();
        check_val("post_flush_empty", 32'(bus.m_valid), 32'd0);

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
        // Stall counter: counting, saturation, clear on flush
        bus.m_ready = 1'b0;
        flush       = 1'b1;
        tick();
        flush = 1'b0;
        check_val("stall_clear0", 32'(stall_cnt), 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hC3;
        tick();
        bus.s_valid = 1'b0;
        repeat (3) tick();
        check_val("stall_cnt3", 32'(stall_cnt), 32'd3);
        repeat (70000) tick();
        check_val("stall_sat", 32'(stall_cnt), 32'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("stall_flush", 32'(stall_cnt), 32'd0);
        check_val("stall_flush_m_valid", 32'(bus.m_valid), 32'd0);
`endif

        // Asynchronous reset between edges while FULL
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h77;
        tick();
        bus.s_data = 8'h88;
        tick();
        bus.s_valid = 1'b0;
        check_val("arst_pre_s_ready", 32'(bus.s_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_m_valid", 32'(bus.m_valid), 32'd0);
        check_val("arst_s_ready", 32'(bus.s_ready), 32'd1);
        check_val("arst_m_data",  32'(bus.m_data),  32'd0);
        tick();
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h99;
        tick();
        bus.s_valid = 1'b0;
        check_val("arst_after_m_valid", 32'(bus.m_valid), 32'd1);
        check_val("arst_after_m_data",  32'(bus.m_data),  32'h99);
        tick();
        check_val("arst_after_empty", 32'(bus.m_valid), 32'd0);

        // Scoreboard bookkeeping
        tick();
        check_val("sb_leftover", 32'(sb.size()), 32'd0);
        check_val("beats_out",   32'(n_out),     32'd22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_buf.md
PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}, giving the reset value of both payload registers.
REQ-003 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port flush, input, 1 bit: synchronous discard of all buffered beats.
REQ-006 Port s_valid, input, 1 bit: upstream beat valid.
REQ-007 Port s_ready, output, 1 bit: block can accept a beat; driven directly from a register.
REQ-008 Port s_data, input, WIDTH bits: upstream payload.
REQ-009 Port m_valid, output, 1 bit: downstream beat valid.
REQ-010 Port m_ready, input, 1 bit: downstream accepts the beat.
REQ-011 Port m_data, output, WIDTH bits: downstream payload; driven directly from the main register.
REQ-012 Port stall_cnt, output, 16 bits: back-pressure cycle count; present only per REQ-030.

Function
REQ-013 A beat SHALL transfer upstream when s_valid & s_ready, and downstream when m_valid & m_ready.
REQ-014 The block SHALL hold two payload registers, main (drives m_data) and skid, with a 3-state FSM: EMPTY, BUSY (main full), FULL (main and skid full).
REQ-015 Outputs SHALL decode as: m_valid = (state != EMPTY); s_ready = registered (next_state != FULL).
REQ-016 EMPTY: on s_valid, main <= s_data and go to BUSY; otherwise stay.
REQ-017 BUSY: s_valid & m_ready: main <= s_data, stay BUSY; s_valid & !m_ready: skid <= s_data, go FULL; !s_valid & m_ready: go EMPTY; otherwise hold.
REQ-018 FULL: s_ready is 0 and s_data is ignored; on m_ready, main <= skid and go BUSY; otherwise hold.
REQ-019 Latency SHALL be one cycle: a beat accepted at edge N is presented on m_data with m_valid = 1 after edge N.
REQ-020 At full throughput (s_valid = m_ready = 1 every cycle) the block SHALL pass one beat per cycle with no bubbles.
REQ-021 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated except by flush.
REQ-022 m_data and m_valid SHALL remain stable while m_valid & !m_ready.
REQ-023 flush SHALL override every other transition: next state EMPTY, s_ready = 1, payload registers unchanged; a beat offered in the flush cycle SHALL be discarded.
REQ-024 Payload registers SHALL load only on the transfers listed in REQ-016..018 (clock-enabled), never otherwise.

Reset
REQ-025 On rst_n low the state SHALL be EMPTY, m_valid = 0, s_ready = 1, main = skid = RESET_VALUE, and stall_cnt = 0, regardless of clk.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered beats; no beat SHALL be emitted during reset.
REQ-027 The first transfer SHALL be possible at the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 The block SHALL use the macro PIPE_SKID_BUF_STALL_CNT_EN.
REQ-029 Macro defined: stall_cnt SHALL increment each cycle in which m_valid & !m_ready, saturate at 16'hFFFF, and clear on flush or reset.
REQ-030 Macro undefined: the stall_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset then s_valid = 1, s_data = 8'hA5, m_ready = 1 -> after 1 edge m_valid = 1, m_data = 8'hA5.
REQ-032 Stream 8'h01..8'h10 with m_ready = 1 continuously -> 16 beats out in order, m_valid high for 16 consecutive cycles, s_ready never 0.
REQ-033 m_ready = 0, offer 8'h11, 8'h22, 8'h33 -> s_ready drops after 8'h22 is accepted; raise m_ready -> outputs 8'h11, 8'h22, then 8'h33 is accepted, nothing lost.
REQ-034 FULL holding 8'h11/8'h22, assert flush for 1 cycle -> m_valid = 0, s_ready = 1 next cycle; 8'h22 is never emitted.
REQ-035 With macro defined, m_valid = 1 and m_ready = 0 for 70000 cycles -> stall_cnt = 16'hFFFF; flush -> 0.
REQ-036 rst_n pulsed low between clk edges while FULL -> m_valid = 0, s_ready = 1, m_data = RESET_VALUE immediately.
